// File: rtl/iob2axil_pkg.sv
// iob2axil_pkg
//   Shared definitions for the IOb-to-AXI-Lite bridge:
//     - state_t          : bridge FSM state encoding
//     - AXI_RESP_OKAY    : AXI response code 2'b00
//     - AXI_RESP_SLVERR  : AXI response code 2'b10
//     - AXI_PROT_DEFAULT : value driven on AWPROT/ARPROT
package iob2axil_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/iob_reg.sv
// iob_reg
//   Generic register with asynchronous active-low reset and load enable.
//   Ports:
//     clk_i    : clock
//     arst_n_i : asynchronous active-low reset (loads RST_VAL)
//     en_i     : load enable
//     data_i   : next value
//     data_o   : registered value
module iob_reg #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_data <= RST_VAL;
    end else if (en_i) begin
      r_data <= data_i;
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/iob2axil.sv
// iob2axil
//   Bridges one outstanding IOb request onto an AXI-Lite master port.
//   Writes (wstrb_i != 0) issue AW and W together and wait for B; reads
//   issue AR and return the R data on rdata_o with a one-cycle rvalid_o.
//   Ports:
//     clk_i, arst_n_i        : clock, asynchronous active-low reset
//     valid_i/addr_i/wdata_i/wstrb_i, rdata_o/rvalid_o/ready_o : IOb slave
//     axil_aw*/axil_w*/axil_b* : AXI-Lite write channels (master side)
//     axil_ar*/axil_r*         : AXI-Lite read channels (master side)
//     err_o (only with IOB2AXIL_ERR_EN defined) : one-cycle pulse when the
//       completed transaction returned a non-OKAY response
//   Optional feature macro: IOB2AXIL_ERR_EN
module iob2axil
  import iob2axil_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  // IOb slave
  input  logic                     valid_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/8-1:0]      wstrb_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rvalid_o,
  output logic                     ready_o,
  // AXI-Lite write
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]               axil_awprot_o,
  output logic                     axil_awvalid_o,
  input  logic                     axil_awready_i,
  output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
  output logic                     axil_wvalid_o,
  input  logic                     axil_wready_i,
  input  logic [1:0]               axil_bresp_i,
  input  logic                     axil_bvalid_i,
  output logic                     axil_bready_o,
  // AXI-Lite read
  output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]               axil_arprot_o,
  output logic                     axil_arvalid_o,
  input  logic                     axil_arready_i,
  input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]               axil_rresp_i,
  input  logic                     axil_rvalid_i,
  output logic                     axil_rready_o
`ifdef IOB2AXIL_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int STRB_W = DATA_W / 8;

  logic [STATE_W-1:0] r_state;
  state_t             w_state;
  state_t             w_state_next;
  logic               r_started;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic               r_aw_done;
  logic               r_w_done;
  logic               w_aw_done_next;
  logic               w_w_done_next;
  logic               r_rvalid;
  logic               w_rvalid_next;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_rdata_en;
  logic               w_accept;
  logic               w_aw_hs;
  logic               w_w_hs;

  assign w_state = state_t'(r_state);

  iob_reg #(.DATA_W(STATE_W), .RST_VAL(IDLE)) u_state_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(w_state_next), .data_o(r_state)
  );

  // Keeps ready_o low while reset is held; rises on the first edge after release.
  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_started_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(1'b1), .data_o(r_started)
  );

  iob_reg #(.DATA_W(ADDR_W), .RST_VAL('0)) u_addr_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(w_accept),
    .data_i(addr_i), .data_o(r_addr)
  );

  iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_wdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(w_accept),
    .data_i(wdata_i), .data_o(r_wdata)
  );

  iob_reg #(.DATA_W(STRB_W), .RST_VAL('0)) u_wstrb_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(w_accept),
    .data_i(wstrb_i), .data_o(r_wstrb)
  );

  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_aw_done_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(w_aw_done_next), .data_o(r_aw_done)
  );

  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_w_done_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(w_w_done_next), .data_o(r_w_done)
  );

  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_rvalid_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(w_rvalid_next), .data_o(r_rvalid)
  );

  iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_rdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(w_rdata_en),
    .data_i(axil_rdata_i), .data_o(r_rdata)
  );

  assign ready_o  = r_started & (w_state == IDLE);
  assign w_accept = valid_i & ready_o;
  assign w_aw_hs  = axil_awvalid_o & axil_awready_i;
  assign w_w_hs   = axil_wvalid_o & axil_wready_i;

  always_comb begin
    w_state_next   = w_state;
    w_aw_done_next = 1'b0;
    w_w_done_next  = 1'b0;
    w_rvalid_next  = 1'b0;
    w_rdata_en     = 1'b0;
    case (w_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (|wstrb_i) ? WRITE : READ;
        end
      end
      WRITE: begin
        // AW and W complete independently; leave once both are done and
        // clear the flags so the next write starts fresh.
        w_aw_done_next = r_aw_done | w_aw_hs;
        w_w_done_next  = r_w_done | w_w_hs;
        if (w_aw_done_next && w_w_done_next) begin
          w_state_next   = WRESP;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
        end
      end
      WRESP: begin
        if (axil_bvalid_i) begin
          w_state_next = IDLE;
        end
      end
      READ: begin
        if (axil_arready_i) begin
          w_state_next = RDATA;
        end
      end
      RDATA: begin
        if (axil_rvalid_i) begin
          w_state_next  = IDLE;
          w_rvalid_next = 1'b1;
          w_rdata_en    = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign axil_awaddr_o  = AXIL_ADDR_W'(r_addr);
  assign axil_awprot_o  = AXI_PROT_DEFAULT;
  assign axil_awvalid_o = (w_state == WRITE) & ~r_aw_done;
  assign axil_wdata_o   = r_wdata;
  assign axil_wstrb_o   = r_wstrb;
  assign axil_wvalid_o  = (w_state == WRITE) & ~r_w_done;
  assign axil_bready_o  = (w_state == WRESP);
  assign axil_araddr_o  = AXIL_ADDR_W'(r_addr);
  assign axil_arprot_o  = AXI_PROT_DEFAULT;
  assign axil_arvalid_o = (w_state == READ);
  assign axil_rready_o  = (w_state == RDATA);
  assign rdata_o        = r_rdata;
  assign rvalid_o       = r_rvalid;

`ifdef IOB2AXIL_ERR_EN
  // Registered so a read error lines up with rvalid_o; a write error
  // appears the cycle after the B handshake.
  logic w_err_next;
  assign w_err_next =
      ((w_state == RDATA) & axil_rvalid_i & (axil_rresp_i != AXI_RESP_OKAY)) |
      ((w_state == WRESP) & axil_bvalid_i & (axil_bresp_i != AXI_RESP_OKAY));

  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_err_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(1'b1),
    .data_i(w_err_next), .data_o(err_o)
  );
`else
  // Responses are not inspected in this build.
  logic w_unused_resp;
  assign w_unused_resp = ^{axil_bresp_i, axil_rresp_i};
`endif

endmodule

// File: tb/tb_iob2axil.sv
// tb_iob2axil
//   Table-driven bench for iob2axil with a behavioural AXI-Lite slave whose
//   per-channel wait states are set per vector. Hand-written sequences cover
//   back-to-back issue and reset during RDATA. Build with IOB2AXIL_ERR_EN to
//   also check err_o.
module tb_iob2axil;
  import iob2axil_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        valid_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        ready_o;
  logic [31:0] axil_awaddr_o;
  logic [2:0]  axil_awprot_o;
  logic        axil_awvalid_o;
  logic        axil_awready_i;
  logic [31:0] axil_wdata_o;
  logic [3:0]  axil_wstrb_o;
  logic        axil_wvalid_o;
  logic        axil_wready_i;
  logic [1:0]  axil_bresp_i;
  logic        axil_bvalid_i;
  logic        axil_bready_o;
  logic [31:0] axil_araddr_o;
  logic [2:0]  axil_arprot_o;
  logic        axil_arvalid_o;
  logic        axil_arready_i;
  logic [31:0] axil_rdata_i;
  logic [1:0]  axil_rresp_i;
  logic        axil_rvalid_i;
  logic        axil_rready_o;
`ifdef IOB2AXIL_ERR_EN
  logic        err_o;
`endif

  always #5 clk = ~clk;

  iob2axil #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i),
    .valid_i(valid_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .ready_o(ready_o),
    .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
    .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
    .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
    .axil_bresp_i(axil_bresp_i), .axil_bvalid_i(axil_bvalid_i),
    .axil_bready_o(axil_bready_o),
    .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
    .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
    .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
    .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o)
`ifdef IOB2AXIL_ERR_EN
    , .err_o(err_o)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural AXI-Lite slave ----------------
  // Outputs change on the falling edge; handshakes are detected one falling
  // edge later from the values that were stable across the rising edge.
  int          cfg_aw_dly, cfg_w_dly, cfg_r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] mem [0:63];
  logic        aw_got, w_got, r_pend;
  int          aw_cnt, w_cnt, r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr, p_awaddr;
  logic [3:0]  s_wstrb;
  logic [35:0] p_w;
  logic        p_awv, p_wv, p_bready, p_arv, p_rready;
  int          cnt_aw_hi = 0, cnt_w_hi = 0, cnt_b_hs = 0, cnt_ar_hs = 0, cnt_unstable = 0;

  always @(negedge clk) begin
    if (!arst_n_i) begin
      axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bvalid_i = 1'b0;
      axil_bresp_i = 2'b00; axil_arready_i = 1'b0; axil_rvalid_i = 1'b0;
      axil_rdata_i = 32'h0; axil_rresp_i = 2'b00;
      aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0;
      aw_cnt = 0; w_cnt = 0; r_cnt = 0;
      p_awv = 1'b0; p_wv = 1'b0; p_bready = 1'b0; p_arv = 1'b0; p_rready = 1'b0;
      p_awaddr = 32'h0; p_w = 36'h0;
    end else begin
      if (p_awv && axil_awready_i) aw_got = 1'b1;
      if (p_wv && axil_wready_i) w_got = 1'b1;
      if (p_bready && axil_bvalid_i) begin axil_bvalid_i = 1'b0; cnt_b_hs++; end
      if (p_arv && axil_arready_i) begin r_pend = 1'b1; r_cnt = 0; cnt_ar_hs++; end
      if (p_rready && axil_rvalid_i) begin axil_rvalid_i = 1'b0; r_pend = 1'b0; end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
        aw_got = 1'b0; w_got = 1'b0;
        axil_bvalid_i = 1'b1; axil_bresp_i = cfg_bresp;
      end
      if (p_awv && axil_awvalid_o && (axil_awaddr_o != p_awaddr)) cnt_unstable++;
      if (p_wv && axil_wvalid_o && ({axil_wdata_o, axil_wstrb_o} != p_w)) cnt_unstable++;
      if (axil_awvalid_o) cnt_aw_hi++;
      if (axil_wvalid_o) cnt_w_hi++;
      axil_awready_i = 1'b0;
      if (axil_awvalid_o) begin
        if (aw_cnt >= cfg_aw_dly) begin
          axil_awready_i = 1'b1; s_awaddr = axil_awaddr_o; aw_cnt = 0;
        end else aw_cnt++;
      end else aw_cnt = 0;
      axil_wready_i = 1'b0;
      if (axil_wvalid_o) begin
        if (w_cnt >= cfg_w_dly) begin
          axil_wready_i = 1'b1; s_wdata = axil_wdata_o; s_wstrb = axil_wstrb_o; w_cnt = 0;
        end else w_cnt++;
      end else w_cnt = 0;
      axil_arready_i = axil_arvalid_o;
      if (axil_arvalid_o) s_araddr = axil_araddr_o;
      if (r_pend && !axil_rvalid_i) begin
        if (r_cnt >= cfg_r_dly) begin
          axil_rvalid_i = 1'b1; axil_rdata_i = mem[s_araddr[7:2]]; axil_rresp_i = cfg_rresp;
        end else r_cnt++;
      end
      p_awv = axil_awvalid_o; p_wv = axil_wvalid_o; p_bready = axil_bready_o;
      p_arv = axil_arvalid_o; p_rready = axil_rready_o;
      p_awaddr = axil_awaddr_o; p_w = {axil_wdata_o, axil_wstrb_o};
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    logic [1:0]  resp;
    int          exp_lat;   // cycles from acceptance to ready_o high again
    logic [31:0] exp_rd;    // rdata_o at completion (held value for writes)
  } vec_t;

  vec_t vecs [12];

  // Issues one request from a rising edge + 1 with ready_o high and
  // follows it to completion (bounded).
  task automatic do_txn(input vec_t v, output int lat, output logic [31:0] rd,
                        output int npulse, output logic errp);
    valid_i = 1'b1; addr_i = v.addr; wdata_i = v.wdata; wstrb_i = v.wstrb;
    @(posedge clk); #1;
    valid_i = 1'b0; wstrb_i = 4'h0;
    lat = 0; npulse = 0; errp = 1'b0; rd = 32'hx;
    for (int c = 1; c <= 40; c++) begin
      if (rvalid_o) npulse++;
`ifdef IOB2AXIL_ERR_EN
      errp = errp | err_o;
`endif
      if (ready_o) begin lat = c; rd = rdata_o; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (rvalid_o) npulse++;
`ifdef IOB2AXIL_ERR_EN
    errp = errp | err_o;
`endif
  endtask

  initial begin
    int          lat, npulse, b0, aw0, w0, ar0, un0, rdy_c, rv_c, rv_cnt;
    logic [31:0] rd;
    logic        errp, taken, drop, in_rdata;

    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, AXI_RESP_OKAY,   3, 32'h00000000};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 4, AXI_RESP_OKAY,   7, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h14, 32'h12345678, 4'h3, 0, 0, 0, AXI_RESP_OKAY,   3, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h14, 32'h0,        4'h0, 0, 0, 0, AXI_RESP_OKAY,   3, 32'h00005678};
    vecs[4]  = '{1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 3, 0, 0, AXI_RESP_OKAY,   6, 32'h00005678};
    vecs[5]  = '{1'b1, 32'h1C, 32'hA5A5A5A5, 4'hF, 0, 2, 0, AXI_RESP_OKAY,   5, 32'h00005678};
    vecs[6]  = '{1'b0, 32'h18, 32'h0,        4'h0, 0, 0, 0, AXI_RESP_OKAY,   3, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 0, 0, 1, AXI_RESP_SLVERR, 4, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 32'h10, 32'h11223344, 4'h4, 0, 0, 0, AXI_RESP_SLVERR, 3, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, AXI_RESP_OKAY,   3, 32'hDE22BEEF};
    vecs[10] = '{1'b1, 32'h24, 32'h0BADC0DE, 4'hF, 2, 2, 0, AXI_RESP_OKAY,   5, 32'hDE22BEEF};
    vecs[11] = '{1'b0, 32'h24, 32'h0,        4'h0, 0, 0, 2, AXI_RESP_OKAY,   5, 32'h0BADC0DE};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    valid_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; wstrb_i = 4'h0;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_r_dly = 0;
    cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY;

    // ---- reset state ----
    arst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready_o}, 32'h0);
    check("rst_valids", {27'h0, axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o, axil_rready_o}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", axil_awaddr_o | axil_araddr_o, 32'h0);
    check("prot", {26'h0, axil_awprot_o, axil_arprot_o}, 32'h0);
    @(negedge clk) arst_n_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'h0, ready_o}, 32'h1);

    // ---- table-driven transactions ----
    for (int i = 0; i < 12; i++) begin
      cfg_aw_dly = vecs[i].aw_dly; cfg_w_dly = vecs[i].w_dly; cfg_r_dly = vecs[i].r_dly;
      cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp;
      b0 = cnt_b_hs; aw0 = cnt_aw_hi; w0 = cnt_w_hi; ar0 = cnt_ar_hs; un0 = cnt_unstable;
      do_txn(vecs[i], lat, rd, npulse, errp);
      $display("txn %0d %s addr=%h wdata=%h wstrb=%h lat=%0d rdata=%h pulses=%0d",
               i, vecs[i].we ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
               lat, rd, npulse);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_rvalid_pulses", i), 32'(npulse), vecs[i].we ? 32'd0 : 32'd1);
      check($sformatf("v%0d_b_hs", i), 32'(cnt_b_hs - b0), vecs[i].we ? 32'd1 : 32'd0);
      check($sformatf("v%0d_ar_hs", i), 32'(cnt_ar_hs - ar0), vecs[i].we ? 32'd0 : 32'd1);
      check($sformatf("v%0d_awvalid_cycles", i), 32'(cnt_aw_hi - aw0),
            vecs[i].we ? 32'(vecs[i].aw_dly + 1) : 32'd0);
      check($sformatf("v%0d_wvalid_cycles", i), 32'(cnt_w_hi - w0),
            vecs[i].we ? 32'(vecs[i].w_dly + 1) : 32'd0);
      check($sformatf("v%0d_stable", i), 32'(cnt_unstable - un0), 32'd0);
`ifdef IOB2AXIL_ERR_EN
      check($sformatf("v%0d_err", i), {31'h0, errp}, {31'h0, vecs[i].resp != AXI_RESP_OKAY});
`endif
    end

    // ---- back-to-back: read held on valid_i while busy, taken when ready rises ----
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_r_dly = 0;
    cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY;
    ar0 = cnt_ar_hs; rdy_c = 0; rv_c = 0; rd = 32'hx; taken = 1'b0;
    valid_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1; wstrb_i = 4'hF;
    @(posedge clk); #1;
    wdata_i = 32'h0; wstrb_i = 4'h0;
    for (int c = 1; c <= 30; c++) begin
      drop = 1'b0;
      if (ready_o && !taken) begin taken = 1'b1; rdy_c = c; drop = 1'b1; end
      if (rvalid_o) begin rv_c = c; rd = rdata_o; break; end
      @(posedge clk); #1;
      if (drop) valid_i = 1'b0;
    end
    valid_i = 1'b0;
    $display("txn b2b WR 0x20 then RD 0x20 ready_at=%0d rvalid_at=%0d rdata=%h", rdy_c, rv_c, rd);
    check("b2b_ready_cycle", 32'(rdy_c), 32'd3);
    check("b2b_rvalid_cycle", 32'(rv_c), 32'd6);
    check("b2b_rdata", rd, 32'h00000001);
    check("b2b_ar_hs", 32'(cnt_ar_hs - ar0), 32'd1);
    @(posedge clk); #1;

    // ---- reset while waiting in RDATA ----
    cfg_r_dly = 5;
    valid_i = 1'b1; addr_i = 32'h10; wstrb_i = 4'h0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    in_rdata = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (axil_rready_o) begin in_rdata = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_mid_reached_rdata", {31'h0, in_rdata}, 32'h1);
    #2 arst_n_i = 1'b0;
    #1;
    check("rst_mid_ready", {31'h0, ready_o}, 32'h0);
    check("rst_mid_valids", {27'h0, axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o, axil_rready_o}, 32'h0);
    check("rst_mid_rvalid", {31'h0, rvalid_o}, 32'h0);
    check("rst_mid_rdata", rdata_o, 32'h0);
    @(negedge clk);
    @(negedge clk) arst_n_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready_after", {31'h0, ready_o}, 32'h1);
    rv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (rvalid_o) rv_cnt++;
      @(posedge clk); #1;
    end
    $display("txn rst_in_rdata RD 0x10 abandoned, rvalid pulses after release=%0d", rv_cnt);
    check("rst_mid_no_rvalid", 32'(rv_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
